// File: rtl/multicycle_ctrl_pw_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller (master) receives the current opcode and the memory
// completion flag and drives every datapath select/strobe, the state code,
// the halted flag and the retired-instruction count. The datapath or a
// bench uses the slave modport.
interface multicycle_ctrl_pw_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic [1:0]         alu_src_b;
  logic               alu_src_a;
  logic               beq_bne;
  logic               reg_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               mem_write;
  logic               mem_read;
  logic               iord;
  logic               pc_write;
  logic               pc_write_cond;
  logic               nbit_branch_select;
  logic [3:0]         state;
  logic               halted;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  op, mem_ready,
    output alu_op, pc_source, alu_src_b, alu_src_a, beq_bne, reg_write,
           ir_write, mem_to_reg, mem_write, mem_read, iord, pc_write,
           pc_write_cond, nbit_branch_select, state, halted, retired
  );

  modport slave (
    output op, mem_ready,
    input  alu_op, pc_source, alu_src_b, alu_src_a, beq_bne, reg_write,
           ir_write, mem_to_reg, mem_write, mem_read, iord, pc_write,
           pc_write_cond, nbit_branch_select, state, halted, retired
  );
endinterface

// File: rtl/multicycle_ctrl_pw.sv
// Multicycle CPU control unit with a retired-instruction counter.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset (state FETCH, counter 0)
//   bus  - multicycle_ctrl_pw_if.master: op/mem_ready in; ALU/PC selects,
//          datapath strobes, state code, halted flag and retired count out.
// All outputs are decoded from the state register and op; only ir_write and
// pc_write in FETCH additionally depend on mem_ready.
module multicycle_ctrl_pw #(
  parameter int              OP_W    = 6,
  parameter int              ALUOP_W = 3,
  parameter int              CNT_W   = 16,
  parameter logic [OP_W-1:0] OP_JUMP = 6'b000001,
  parameter logic [OP_W-1:0] OP_LWI  = 6'b111011,
  parameter logic [OP_W-1:0] OP_SW   = 6'b111100,
  parameter logic [OP_W-1:0] OP_HALT = 6'b000010
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_pw_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_I  = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_BR_CMP  = 4'd8,
    S_JUMP    = 4'd9,
    S_BR_PREP = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b011);

  state_t           state_q, state_d, out_state;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  logic [1:0]       op_class;
  logic             is_lwi, is_sw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign op_class = bus.op[OP_W-1 -: 2];
  assign is_lwi   = (bus.op == OP_LWI);
  assign is_sw    = (bus.op == OP_SW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= sat_inc(retired_q);
    end
  end

  // Next state. retire marks a completed instruction returning to FETCH;
  // entry into HALT and recovery from an unused code are not retirements.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          2'b01:   state_d = S_EXEC_R;
          2'b10:   state_d = S_BR_PREP;
          2'b11:   state_d = S_EXEC_I;
          default: begin
            if (bus.op == OP_JUMP)      state_d = S_JUMP;
            else if (bus.op == OP_HALT) state_d = S_HALT;
            else begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
        endcase
      end
      S_EXEC_I: begin
        if (is_lwi)     state_d = S_MEM_RD;
        else if (is_sw) state_d = S_MEM_WR;
        else            state_d = S_WB_ALU;
      end
      S_MEM_RD:  if (bus.mem_ready) state_d = S_WB_MEM;
      S_WB_MEM: begin state_d = S_FETCH; retire = 1'b1; end
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R:  state_d = S_WB_ALU;
      S_WB_ALU:  begin state_d = S_FETCH; retire = 1'b1; end
      S_BR_PREP: state_d = S_BR_CMP;
      S_BR_CMP:  begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:    begin state_d = S_FETCH; retire = 1'b1; end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // While rst is high the outputs present FETCH, so a reset taken in the
  // middle of a memory access drops the access request immediately.
  assign out_state = rst ? S_FETCH : state_q;

  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source, alu_src_b;
  logic               alu_src_a, beq_bne, reg_write, ir_write, mem_to_reg;
  logic               mem_write, mem_read, iord, pc_write, pc_write_cond;
  logic               nbit_sel, halted;

  always_comb begin
    alu_op        = '0;
    pc_source     = 2'b00;
    alu_src_b     = 2'b00;
    alu_src_a     = 1'b0;
    beq_bne       = 1'b0;
    reg_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    iord          = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    nbit_sel      = 1'b0;
    halted        = 1'b0;
    case (out_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      S_DECODE, S_BR_PREP: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        beq_bne   = bus.op[0];
        nbit_sel  = (op_class != 2'b10);
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_op    = (is_lwi || is_sw) ? ALU_ADD : bus.op[ALUOP_W-1:0];
        // Immediate forms selecting the alternate B operand; LWI shares an
        // encoding with them but must use the address offset path.
        if ((bus.op[2:0] == 3'b010 || bus.op[2:0] == 3'b011 ||
             bus.op[2:0] == 3'b111) && !is_lwi)
          alu_src_b = 2'b10;
        else
          alu_src_b = 2'b11;
        nbit_sel = !(is_lwi || is_sw);
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        nbit_sel = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nbit_sel   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        nbit_sel  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = bus.op[ALUOP_W-1:0];
        nbit_sel  = 1'b1;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        nbit_sel  = 1'b1;
      end
      S_BR_CMP: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        beq_bne       = bus.op[0];
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        nbit_sel  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.alu_op             = alu_op;
  assign bus.pc_source          = pc_source;
  assign bus.alu_src_b          = alu_src_b;
  assign bus.alu_src_a          = alu_src_a;
  assign bus.beq_bne            = beq_bne;
  assign bus.reg_write          = reg_write;
  assign bus.ir_write           = ir_write;
  assign bus.mem_to_reg         = mem_to_reg;
  assign bus.mem_write          = mem_write;
  assign bus.mem_read           = mem_read;
  assign bus.iord               = iord;
  assign bus.pc_write           = pc_write;
  assign bus.pc_write_cond      = pc_write_cond;
  assign bus.nbit_branch_select = nbit_sel;
  assign bus.state              = out_state;
  assign bus.halted             = halted;
  assign bus.retired            = retired_q;

endmodule

// File: doc/multicycle_ctrl_pw.md
MULTICYCLE_CTRL_PW -- requirements
Module: multicycle_ctrl_pw

Interface
REQ-001 Parameter OP_W, default 6, opcode width (minimum 4).
REQ-002 Parameter ALUOP_W, default 3, ALU operation code width.
REQ-003 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-004 Parameters OP_JUMP / OP_LWI / OP_SW / OP_HALT, defaults 6'b000001 / 6'b111011 / 6'b111100 / 6'b000010, special opcodes.
REQ-005 Ports, clock and reset first:
- clk  in  1  clock; rst is synchronous, active-high.
- rst  in  1  reset.
- op  in  OP_W  opcode of the current instruction.
- mem_ready  in  1  memory completes the current access this cycle.
- alu_op  out  ALUOP_W  ALU operation.
- pc_source, alu_src_b  out  2 each  PC and ALU-B mux selects.
- alu_src_a, beq_bne, reg_write, ir_write, mem_to_reg, mem_write, mem_read, iord, pc_write, pc_write_cond, nbit_branch_select  out  1 each  datapath controls.
- state  out  4  current state code.
- halted  out  1  core is halted.
- retired  out  CNT_W  count of retired instructions.

Function
REQ-006 The state register SHALL use these codes: FETCH=0, DECODE=1, EXEC_I=2, MEM_RD=3, WB_MEM=4, MEM_WR=5, EXEC_R=6, WB_ALU=7, BR_CMP=8, JUMP=9, BR_PREP=10, HALT=11; codes 12-15 SHALL go to FETCH with all controls 0.
- ADD is alu_op 'b010; SUB is 'b011.
- Each output not listed for a state SHALL be 0.
REQ-007 FETCH: mem_read=1, alu_src_b=01, alu_op=ADD.
- ir_write=1 and pc_write=1 only in a cycle where mem_ready=1; the state then advances to DECODE.
- While mem_ready=0 the state holds and no register-write strobe is asserted.
REQ-008 DECODE: alu_src_b=11, alu_op=ADD, beq_bne=op[0].
- nbit_branch_select = 0 if op[OP_W-1:OP_W-2]==10, else 1.
REQ-009 DECODE next state is selected by the class op[OP_W-1:OP_W-2]:
- 01 -> EXEC_R.
- 10 -> BR_PREP.
- 11 -> EXEC_I.
- 00 with op==OP_JUMP -> JUMP.
- 00 with op==OP_HALT -> HALT.
- any other 00 (NOP) -> FETCH.
REQ-010 EXEC_I: alu_src_a=1.
- alu_op = ADD for OP_LWI or OP_SW, else op[ALUOP_W-1:0].
- alu_src_b = 10 when op[2:0] is 010, 011 or 111 and op!=OP_LWI, else 11.
- nbit_branch_select = 0 for OP_LWI/OP_SW, else 1.
- Next state: OP_LWI -> MEM_RD; OP_SW -> MEM_WR; otherwise -> WB_ALU.
REQ-011 MEM_RD: mem_read=1, iord=1; holds until mem_ready=1, then goes to WB_MEM.
REQ-012 WB_MEM: reg_write=1, mem_to_reg=1; goes to FETCH.
REQ-013 MEM_WR: mem_write=1, iord=1; holds until mem_ready=1, then goes to FETCH.
REQ-014 EXEC_R: alu_src_a=1, alu_op=op[ALUOP_W-1:0]; goes to WB_ALU.
REQ-015 WB_ALU: reg_write=1, alu_src_b=11, alu_op=ADD; goes to FETCH.
REQ-016 BR_PREP: same outputs as DECODE; goes to BR_CMP.
REQ-017 BR_CMP: alu_src_a=1, alu_op=SUB, pc_source=01, pc_write_cond=1, beq_bne=op[0], nbit_branch_select=0; goes to FETCH.
REQ-018 JUMP: pc_source=10, pc_write=1; goes to FETCH.
REQ-019 HALT: halted=1 and all strobes 0; the state holds until rst.
REQ-020 nbit_branch_select SHALL be 1 in MEM_RD, WB_MEM, MEM_WR, EXEC_R, WB_ALU and JUMP, and 0 in FETCH and HALT.
REQ-021 retired SHALL increment by 1 on each transition into FETCH from WB_MEM, MEM_WR, WB_ALU, BR_CMP, JUMP or DECODE (NOP).
- It saturates at all-ones.
- It does not increment on entry to HALT.
REQ-022 Every output except the mem_ready-gated strobes of REQ-007 SHALL be a function of state and op only.

Reset
REQ-023 When rst=1 at a clock edge: state=FETCH, retired=0, halted=0; this takes priority over every transition.
- This includes reset during a memory wait or in HALT; a pending access is abandoned.
REQ-024 During reset the outputs SHALL be the FETCH values of REQ-007, with ir_write/pc_write still gated by mem_ready.

Verification
REQ-025 Apply R-type op 6'b010110 with mem_ready=1 -> state sequence 0,1,6,7,0; alu_op=3'b110 in EXEC_R; reg_write=1 in WB_ALU; retired +1.
REQ-026 Apply OP_LWI with mem_ready low for 3 cycles in MEM_RD -> state sequence 0,1,2,3,3,3,3,4,0; mem_read and iord stay high while waiting; reg_write=0 until WB_MEM.
REQ-027 Hold mem_ready=0 for 5 cycles in FETCH -> state stays 0; ir_write=pc_write=0 throughout; both pulse for exactly one cycle when mem_ready rises.
REQ-028 Apply branch op 6'b100001 -> sequence 0,1,10,8,0; in BR_CMP pc_write_cond=1, beq_bne=1, pc_source=01, alu_op=SUB.
REQ-029 Apply OP_HALT -> halted=1 and state=11 indefinitely with retired unchanged; then assert rst for 1 cycle -> state 0, halted 0, retired 0.
REQ-030 With CNT_W=2, retire 5 NOPs -> retired reads 1,2,3,3,3.
